// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle integer divider.
// Holds the FSM state encodings and the EX-stage ALU control codes that
// select DIV/DIVU.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // EX decodes these into start/signed_div.
    localparam logic [4:0] EXE_DIV_OP  = 5'h0A;
    localparam logic [4:0] EXE_DIVU_OP = 5'h0B;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
// Ports: rem/quo = current partial remainder and quotient/dividend shift
//        register, divisor = divisor magnitude; rem_nx/quo_nx = next values.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nx,
    output logic [WIDTH-1:0] quo_nx
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The shifted remainder can exceed WIDTH bits when the divisor has its
    // MSB set, so the trial subtraction keeps one extra bit.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (trial[WIDTH]) begin
            rem_nx = shifted[WIDTH-1:0];
        end else begin
            rem_nx = trial[WIDTH-1:0];
        end
        quo_nx = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU unit for the execute stage, one quotient bit
// per cycle. Ports: clk, rst (sync, active high), start/signed_div/num1/num2
// request, annul abort; busy, ready pulse, div_zero, result={rem,quo}.
import div_unit_pkg::*;

module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   num1,
    input  logic [WIDTH-1:0]   num2,
    input  logic               annul,
    output logic               busy,
    output logic               ready,
    output logic               div_zero,
    output logic [2*WIDTH-1:0] result
);

    div_state_e state;
    div_state_e state_nx;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             q_neg;
    logic             r_neg;

    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             accept;
    logic             last;
    logic             num2_zero;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem    (rem_q),
        .quo    (quo_q),
        .divisor(dvs_q),
        .rem_nx (rem_nx),
        .quo_nx (quo_nx)
    );

    // annul has priority over a simultaneous start in IDLE.
    assign accept    = (state == DIV_IDLE) && start && !annul;
    assign last      = (cnt == CNT_W'(WIDTH - 1));
    assign num2_zero = (num2 == '0);

    assign mag1 = (signed_div && num1[WIDTH-1]) ? -num1 : num1;
    assign mag2 = (signed_div && num2[WIDTH-1]) ? -num2 : num2;

    assign quo_fix = q_neg ? -quo_nx : quo_nx;
    assign rem_fix = r_neg ? -rem_nx : rem_nx;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            DIV_IDLE: begin
                if (accept) begin
                    state_nx = num2_zero ? DIV_DONE : DIV_CALC;
                end
            end
            DIV_CALC: begin
                if (annul) begin
                    state_nx = DIV_IDLE;
                end else if (last) begin
                    state_nx = DIV_DONE;
                end
            end
            DIV_DONE: state_nx = DIV_IDLE;
            default:  state_nx = DIV_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy  = (state == DIV_CALC) || (state == DIV_DONE);
        ready = (state == DIV_DONE);
    end

    // Datapath: operands, iteration counter and the result register.
    // result and div_zero are only written on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            result   <= '0;
        end else if (accept) begin
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= mag1;
            dvs_q <= mag2;
            q_neg <= signed_div && (num1[WIDTH-1] ^ num2[WIDTH-1]);
            r_neg <= signed_div && num1[WIDTH-1];
            if (num2_zero) begin
                div_zero <= 1'b1;
                result   <= '0;
            end
        end else if ((state == DIV_CALC) && !annul) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt   <= cnt + 1'b1;
            if (last) begin
                div_zero <= 1'b0;
                result   <= {rem_fix, quo_fix};
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard testbench for div_unit: directed DIV/DIVU vectors, zero
// divisor, overflow case, annul, ignored start and mid-operation reset.
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_div;
    logic [W-1:0]   num1;
    logic [W-1:0]   num2;
    logic           annul;
    logic           busy;
    logic           ready;
    logic           div_zero;
    logic [2*W-1:0] result;

    div_unit #(
        .WIDTH(W),
        .CNT_W(6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_div(signed_div),
        .num1      (num1),
        .num2      (num2),
        .annul     (annul),
        .busy      (busy),
        .ready     (ready),
        .div_zero  (div_zero),
        .result    (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          at;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          errs = 0;
    int          checks = 0;
    logic [63:0] last_res = '0;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, act, req);
        end
    endtask

    // Monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL spurious_ready: got ready=1 at cycle %0d want 0",
                         cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_res"}, result, e.res);
                chk({e.tag, "_dz"}, 64'(div_zero), 64'(e.dz));
                chk({e.tag, "_cyc"}, 64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic issue(input string tag, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input logic dz,
                         output int t);
        @(negedge clk);
        t          = cyc;
        signed_div = s;
        num1       = a;
        num2       = b;
        start      = 1'b1;
        sb.push_back('{res, dz, cyc + ((b == 0) ? 1 : 33), tag});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errs++;
            $display("FAIL %s_timeout: got %0d pending want 0", tag, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic run(input string tag, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] res, input logic dz);
        int t;
        issue(tag, s, a, b, res, dz, t);
        drain(tag);
        last_res = res;
    endtask

    initial begin
        int t;
        int bad;
        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        num1       = '0;
        num2       = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);
        chk("rst_result", result, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // DIVU 7/2 with busy window T+1..T+33
        issue("divu_7_2", 1'b0, 32'd7, 32'd2, {32'h1, 32'h3}, 1'b0, t);
        bad = 0;
        for (int k = 0; k < 33; k++) begin
            if (busy !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("busy_window", 64'(bad), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
        drain("divu_7_2");

        run("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
            {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
        run("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
            {32'h1, 32'hFFFFFFFD}, 1'b0);
        run("div_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE,
            {32'hFFFFFFFF, 32'h3}, 1'b0);

        run("div_zero", 1'b1, 32'd9, 32'd0, 64'd0, 1'b1);
        chk("dz_idle_busy", 64'(busy), 64'd0);
        run("divu_zero", 1'b0, 32'd9, 32'd0, 64'd0, 1'b1);
        chk("dzu_idle_busy", 64'(busy), 64'd0);

        run("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF,
            {32'h0, 32'h80000000}, 1'b0);
        run("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1,
            {32'h0, 32'hFFFFFFFF}, 1'b0);
        run("divu_max_msb", 1'b0, 32'hFFFFFFFF, 32'h80000000,
            {32'h7FFFFFFF, 32'h1}, 1'b0);
        run("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 1'b0);

        // annul in CALC at T+10, new start at T+12
        issue("annulled", 1'b0, 32'd55, 32'd5, {32'h0, 32'hB}, 1'b0, t);
        wait_cyc(t + 10);
        annul = 1'b1;
        sb.delete();
        @(negedge clk);
        annul = 1'b0;
        chk("annul_busy", 64'(busy), 64'd0);
        chk("annul_result", result, last_res);
        run("after_annul", 1'b0, 32'd1000, 32'd10, {32'h0, 32'h64}, 1'b0);

        // annul together with start in IDLE
        @(negedge clk);
        signed_div = 1'b0;
        num1       = 32'd8;
        num2       = 32'd2;
        start      = 1'b1;
        annul      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        chk("start_annul_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        chk("start_annul_result", result, last_res);

        // annul during DONE does not suppress ready
        issue("annul_done", 1'b0, 32'd9, 32'd4, {32'h1, 32'h2}, 1'b0, t);
        wait_cyc(t + 33);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        drain("annul_done");
        last_res = {32'h1, 32'h2};

        // start while busy is ignored
        issue("ignored_start", 1'b1, 32'hFFFFFF9C, 32'd7,
              {32'hFFFFFFFE, 32'hFFFFFFF2}, 1'b0, t);
        wait_cyc(t + 5);
        signed_div = 1'b0;
        num1       = 32'd5;
        num2       = 32'd5;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("ignored_start");

        // reset in the middle of an operation
        issue("reset_mid", 1'b0, 32'd50, 32'd3, {32'h2, 32'h10}, 1'b0, t);
        wait_cyc(t + 20);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(ready), 64'd0);
        chk("mid_rst_dz", 64'(div_zero), 64'd0);
        chk("mid_rst_result", result, 64'd0);
        run("after_reset", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
